// File: rtl/rv32m_seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; start/done handshake toward EX.
module rv32m_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             isrem_q, isrem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] spec_res;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] qfix;
  logic [WIDTH-1:0] rfix;

  assign sgn   = ~op_i[0];
  assign a_neg = sgn & a_i[WIDTH-1];
  assign b_neg = sgn & b_i[WIDTH-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;
  assign div0  = (b_i == '0);
  assign ovf   = sgn && (a_i == MIN_NEG) && (b_i == '1);

  assign spec_res = div0
    ? (op_i[1] ? a_i : '1)
    : (op_i[1] ? '0 : a_i);

  // Keep the shifted-out remainder MSB so large unsigned divisors compare right
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});

  assign qfix = qneg_q ? -quo_q : quo_q;
  assign rfix = rneg_q ? -rem_q : rem_q;

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE) && !flush_i;
  assign result_o = res_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    isrem_d = isrem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          isrem_d = op_i[1];
          dvd_d   = a_abs;
          dvs_d   = b_abs;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(WIDTH);
          if (div0 || ovf) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        if (ge) begin
          rem_d = rem_sh[WIDTH-1:0] - dvs_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        res_d   = isrem_q ? rfix : qfix;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      isrem_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      isrem_q <= isrem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_rv32m_seq_divider.sv
// Directed + random bench for rv32m_seq_divider.
// Scoreboard queue of expected results, immediate-assert checks.
module tb_rv32m_seq_divider;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        ready_o;
  logic        done_o;
  logic [31:0] result_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  rv32m_seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : a;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // lat = rising edges from the accept edge (inclusive) until done_o seen
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit got;
    logic [31:0] e;
    @(negedge clk);
    chk({tag, " ready"}, ready_o, 1);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    lat = 0;
    got = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (done_o) got = 1;
    end
    chk({tag, " latency"}, lat, lat_of(op, a, b));
    e = exp_q.pop_front();
    if (got) begin
      chk({tag, " result"}, result_o, e);
      chk({tag, " ready in done"}, ready_o, 0);
      @(negedge clk);
      chk({tag, " pulse width"}, done_o, 0);
    end
    last_res = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int t1;
    int t2;
    int pushes;
    int ndone;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] e;

    #12;
    chk("reset ready", ready_o, 1);
    chk("reset done", done_o, 0);
    chk("reset result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7);
    run_op("REMU 100/7", 2'b11, 32'd100, 32'd7);
    run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("DIV 5/0", 2'b00, 32'd5, 32'd0);
    run_op("REMU 5/0", 2'b11, 32'd5, 32'd0);
    run_op("DIV ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF);
    run_op("REM ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF);
    run_op("DIVU big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("REMU big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      run_op("random", rop, ra, rb);
    end

    // flush in the DONE cycle of a special-case op suppresses done_o
    @(negedge clk);
    op_i = 2'b00; a_i = 32'd5; b_i = 32'd0; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush in DONE done", done_o, 0);
    chk("flush in DONE ready", ready_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("after DONE flush ready", ready_o, 1);
    chk("after DONE flush done", done_o, 0);

    // flush together with start in IDLE: no accept
    op_i = 2'b01; a_i = 32'd9; b_i = 32'd3;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush+start ready", ready_o, 1);
    @(negedge clk);
    chk("flush+start done", done_o, 0);

    run_op("DIVU pre-flush", 2'b01, 32'd100, 32'd7);

    // flush of an op in CALC
    @(negedge clk);
    op_i = 2'b01; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ndone = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush ready", ready_o, 1);
    chk("flush result held", result_o, last_res);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    chk("flush no done", ndone, 0);
    run_op("DIVU after flush", 2'b01, 32'd100, 32'd7);

    // asynchronous reset in the middle of an op
    @(negedge clk);
    op_i = 2'b00; a_i = 32'hFFFF_FF00; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop reset ready", ready_o, 1);
    chk("midop reset result", result_o, 0);
    chk("midop reset done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    chk("midop reset no done", ndone, 0);

    // start_i held high: one accept per IDLE cycle, none in DONE
    @(negedge clk);
    op_i = 2'b01; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    cnt = 0; t1 = -1; t2 = -1; pushes = 0;
    while (t2 < 0 && cnt < 150) begin
      if (ready_o && start_i) begin
        exp_q.push_back(model(op_i, a_i, b_i));
        pushes++;
      end
      if (done_o) begin
        e = exp_q.pop_front();
        chk("held result", result_o, e);
        if (t1 < 0) t1 = cnt;
        else begin
          t2 = cnt;
          start_i = 1'b0;
        end
      end
      if (t2 < 0) begin
        @(negedge clk);
        cnt++;
      end
    end
    chk("held first done", t1, 34);
    chk("held second done", t2, 69);
    chk("held accepts", pushes, 2);
    @(negedge clk);
    chk("held idle ready", ready_o, 1);
    chk("held queue empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
